// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} between fetch and decode.
// Optional same-cycle bypass into an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [31:0]                in_instr,
    output logic                       full,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_pc_plus4,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic wr_en;

    assign empty = (count_q == '0);
    // full comes straight from a register so the PC stall has no input-to-output path
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & in_valid & ~flush & ~rst;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = ~empty | bypass;
    assign push      = in_valid & ~full;
    assign pop       = out_valid & out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        if (rst || flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (!(bypass && out_ready)) begin
            // a bypassed entry taken the same cycle never touches storage
            wr_en = push;
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

    always_comb begin
        if (!empty) begin
            out_pc    = pc_mem_q[rd_ptr_q];
            out_instr = instr_mem_q[rd_ptr_q];
        end else if (bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else begin
            out_pc    = '0;
            out_instr = NOP;
        end
    end

    assign out_pc_plus4 = out_pc + WIDTH'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
// Honors FETCH_QUEUE_BYPASS_EN the same way the design does.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        full;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic [2:0]  count;

    fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .full(full), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] mq[$];      // {pc, instr}, oldest at index 0
    logic [31:0] rx[$];      // pcs accepted by decode
    bit          armed = 1'b0;
    bit          last_push;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input bit r, input bit f, input bit iv,
                        input logic [31:0] pc, input logic [31:0] ins, input bit rdy);
        bit          e_valid, byp_case, byp_take, push_ok, do_pop;
        logic [63:0] head;
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = rdy;
        #1;
        byp_case = BYP && (mq.size() == 0) && iv && !f && !r;
        e_valid  = (mq.size() != 0) || byp_case;
        if (mq.size() != 0) head = mq[0];
        else if (byp_case)  head = {pc, ins};
        else                head = {32'h0, NOP};
        if (armed) begin
            chk("out_valid", 64'(out_valid), 64'(e_valid));
            chk("full", 64'(full), 64'(mq.size() == DEPTH));
            chk("count", 64'(count), 64'(mq.size()));
            chk("out_pc", 64'(out_pc), 64'(head[63:32]));
            chk("out_instr", 64'(out_instr), 64'(head[31:0]));
            chk("out_pc_plus4", 64'(out_pc_plus4), 64'(32'(head[63:32] + 32'd4)));
        end
        last_push = 1'b0;
        if (r || f) begin
            mq.delete();
        end else begin
            byp_take = byp_case && rdy;
            push_ok  = iv && (mq.size() < DEPTH);
            do_pop   = (mq.size() != 0) && rdy;
            if (e_valid && rdy) rx.push_back(out_pc);
            if (!byp_take) begin
                if (do_pop)  void'(mq.pop_front());
                if (push_ok) mq.push_back({pc, ins});
            end
            last_push = push_ok;
        end
        @(posedge clk);
        #1;
        armed = 1'b1;
    endtask

    task automatic do_reset();
        step(1, 0, 1, 32'h40, 32'h1234, 0);
        step(1, 0, 1, 32'h44, 32'h5678, 0);
    endtask

    initial begin
        // reset with in_valid asserted
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);

        // fill then overflow attempt
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'(i * 4), $urandom, 0);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd4);
        step(0, 0, 1, 32'h10, $urandom, 0);
        chk("drop_count", 64'(count), 64'd4);
        chk("drop_head", 64'(out_pc), 64'h0);

        // drain in order
        rx.delete();
        step(0, 0, 0, 0, 0, 1);
        chk("drain_full", 64'(full), 64'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_n", 64'(rx.size()), 64'd4);
        for (int i = 0; i < rx.size() && i < 4; i++) chk("drain_pc", 64'(rx[i]), 64'(i * 4));

        // simultaneous push/pop at count 2
        step(0, 0, 1, 32'h8, $urandom, 0);
        step(0, 0, 1, 32'hC, $urandom, 0);
        step(0, 0, 1, 32'h20, $urandom, 1);
        chk("pp_count", 64'(count), 64'd2);
        chk("pp_head", 64'(out_pc), 64'hC);

        // flush priority at count 3
        step(0, 0, 1, 32'h24, $urandom, 0);
        chk("pre_flush", 64'(count), 64'd3);
        step(0, 1, 1, 32'h28, $urandom, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_full", 64'(full), 64'd0);
        step(0, 0, 1, 32'h100, 32'h0000_0033, 0);
        chk("redir_head", 64'(out_pc), 64'h100);
        chk("redir_pc4", 64'(out_pc_plus4), 64'h104);
        step(0, 0, 0, 0, 0, 0);

        // wrap-around stream with random out_ready
        do_reset();
        rx.delete();
        begin
            int pushed = 0;
            int cyc = 0;
            while ((pushed < 10 || rx.size() < 10) && cyc < 300) begin
                step(0, 0, pushed < 10, 32'(pushed * 4), $urandom, 1'($urandom_range(0, 1)));
                if (last_push) pushed++;
                cyc++;
            end
        end
        chk("stream_n", 64'(rx.size()), 64'd10);
        for (int i = 0; i < rx.size() && i < 10; i++) chk("stream_pc", 64'(rx[i]), 64'(i * 4));

        // pc+4 wraps at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC, 32'h0000_006F, 0);
        chk("wrap_pc4", 64'(out_pc_plus4), 64'h0);
        step(0, 1, 0, 0, 0, 0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // same-cycle visibility into an empty queue
        step(0, 0, 1, 32'h200, 32'h0000_0093, 1);
        chk("byp_count", 64'(count), 64'd0);
`endif

        // random traffic including flushes and resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
